// File: rtl/jpu_pkg.sv
// Shared types and constants for the JPU memory arbiter: FSM state encoding,
// access-size codes and the alignment-fault rule.
package jpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10,
        FAULT  = 2'b11
    } arb_state_e;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b11;

    // Size code 10 is reserved; halves need even, words need 4-byte alignment.
    function automatic logic size_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_SIZE_B: bad = 1'b0;
            MEM_SIZE_H: bad = addr_lo[0];
            MEM_SIZE_W: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/jpu_mem_lane.sv
// Combinational big-endian byte-lane logic: store byte enables, lane
// replication and fault detection, plus load extraction with sign/zero extend.
module jpu_mem_lane
    import jpu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_lane,
    output logic        st_illegal,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr,
    input  logic        ld_se,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    assign st_illegal = size_illegal(st_size, st_addr);

    // Byte enables and lane replication; address offset 0 is the MSB lane.
    always_comb begin
        st_be         = 4'b0000;
        st_wdata_lane = 32'h0000_0000;
        case (st_size)
            MEM_SIZE_B: begin
                st_be         = 4'b1000 >> st_addr;
                st_wdata_lane = {4{st_wdata[7:0]}};
            end
            MEM_SIZE_H: begin
                st_be         = st_addr[1] ? 4'b0011 : 4'b1100;
                st_wdata_lane = {2{st_wdata[15:0]}};
            end
            MEM_SIZE_W: begin
                st_be         = 4'b1111;
                st_wdata_lane = st_wdata;
            end
            default: begin
                st_be         = 4'b0000;
                st_wdata_lane = 32'h0000_0000;
            end
        endcase
    end

    // Load lane selection followed by extension to 32 bits.
    always_comb begin
        ld_data = 32'h0000_0000;
        case (ld_addr)
            2'b00:   ld_byte_s = ld_rdata[31:24];
            2'b01:   ld_byte_s = ld_rdata[23:16];
            2'b10:   ld_byte_s = ld_rdata[15:8];
            default: ld_byte_s = ld_rdata[7:0];
        endcase
        if (ld_addr[1]) begin
            ld_half_s = ld_rdata[15:0];
        end else begin
            ld_half_s = ld_rdata[31:16];
        end
        case (ld_size)
            MEM_SIZE_B: ld_data = {{24{ld_se & ld_byte_s[7]}}, ld_byte_s};
            MEM_SIZE_H: ld_data = {{16{ld_se & ld_half_s[15]}}, ld_half_s};
            MEM_SIZE_W: ld_data = ld_rdata;
            default:    ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/jpu_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Define JPU_ARB_RR_EN for round-robin on ties; default is data-over-fetch.
module jpu_mem_arbiter
    import jpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_se,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    arb_state_e  state_r;
    arb_state_e  state_s;
    logic        grant_d_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic        st_illegal_s;
    logic [31:0] ld_data_s;
    logic        mem_we_r;
    logic [29:0] mem_addr_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;
    logic [1:0]  ld_size_r;
    logic [1:0]  ld_addr_r;
    logic        ld_se_r;
    logic        unused_s;

    assign unused_s = ^i_addr[1:0];

`ifdef JPU_ARB_RR_EN
    logic last_d_r;

    assign grant_d_s = d_req & ~(i_req & last_d_r);

    // Remembers which requester won the last grant; reset value means data wins the first tie.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_d_r <= 1'b0;
        end else if ((state_r == IDLE) && (state_s != IDLE)) begin
            last_d_r <= (state_s != BUSY_I);
        end else begin
            last_d_r <= last_d_r;
        end
    end
`else
    assign grant_d_s = d_req;
`endif

    jpu_mem_lane u_lane (
        .st_size       (d_size),
        .st_addr       (d_addr[1:0]),
        .st_wdata      (d_wdata),
        .st_be         (st_be_s),
        .st_wdata_lane (st_wdata_s),
        .st_illegal    (st_illegal_s),
        .ld_size       (ld_size_r),
        .ld_addr       (ld_addr_r),
        .ld_se         (ld_se_r),
        .ld_rdata      (mem_rdata),
        .ld_data       (ld_data_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: grants only from IDLE, so an ack cycle never overlaps a new grant.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_s = st_illegal_s ? FAULT : BUSY_D;
                end else if (i_req) begin
                    state_s = BUSY_I;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            FAULT:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Captures the granted request so the memory port stays stable until mem_ready.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 30'h0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            ld_size_r   <= 2'b00;
            ld_addr_r   <= 2'b00;
            ld_se_r     <= 1'b0;
        end else if ((state_r == IDLE) && (state_s == BUSY_D)) begin
            mem_we_r    <= d_we;
            mem_addr_r  <= d_addr[31:2];
            mem_be_r    <= st_be_s;
            mem_wdata_r <= d_we ? st_wdata_s : 32'h0000_0000;
            ld_size_r   <= d_size;
            ld_addr_r   <= d_addr[1:0];
            ld_se_r     <= d_se;
        end else if ((state_r == IDLE) && (state_s == BUSY_I)) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= i_addr[31:2];
            mem_be_r    <= 4'b1111;
            mem_wdata_r <= 32'h0000_0000;
            ld_size_r   <= MEM_SIZE_W;
            ld_addr_r   <= 2'b00;
            ld_se_r     <= 1'b0;
        end else begin
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_be_r    <= mem_be_r;
            mem_wdata_r <= mem_wdata_r;
            ld_size_r   <= ld_size_r;
            ld_addr_r   <= ld_addr_r;
            ld_se_r     <= ld_se_r;
        end
    end

    assign mem_req   = (state_r == BUSY_I) || (state_r == BUSY_D);
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

    // Acks are mem_ready qualified by owner; stray mem_ready elsewhere has no effect.
    assign i_ack   = (state_r == BUSY_I) && mem_ready;
    assign i_rdata = i_ack ? mem_rdata : 32'h0000_0000;
    assign d_ack   = ((state_r == BUSY_D) && mem_ready) || (state_r == FAULT);
    assign d_err   = (state_r == FAULT);
    assign d_rdata = ((state_r == BUSY_D) && mem_ready) ? ld_data_s : 32'h0000_0000;

endmodule

// File: tb/tb_jpu_mem_arbiter.sv
// Self-checking bench for jpu_mem_arbiter: directed scenarios plus randomized
// single-requester traffic against a behavioural lane/priority model.
module tb_jpu_mem_arbiter;

    logic        clk;
    logic        rst_b;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_se;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int vectors = 0;
    int miscompares = 0;

    jpu_mem_arbiter dut (
        .clk(clk), .rst_b(rst_b),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_se(d_se), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the access rules.
    function automatic logic m_illegal(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        return (sz == 2'b10) || (sz == 2'b01 && (off % 2) != 0) || (sz == 2'b11 && off != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        if (sz == 2'b00) return 4'(1 << (3 - off));
        if (sz == 2'b01) return (off >= 2) ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w & 32'h0000_00FF;
        h = w & 32'h0000_FFFF;
        if (sz == 2'b00) return b * 32'h0101_0101;
        if (sz == 2'b01) return h * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic se,
                                            input logic [31:0] a, input logic [31:0] r);
        int off;
        logic [31:0] v;
        off = int'(a % 32'd4);
        if (sz == 2'b00) begin
            v = (r >> (8 * (3 - off))) & 32'h0000_00FF;
            if (se && v >= 32'h80) v = v - 32'h100;
            return v;
        end
        if (sz == 2'b01) begin
            v = (r >> ((off >= 2) ? 0 : 16)) & 32'h0000_FFFF;
            if (se && v >= 32'h8000) v = v - 32'h1_0000;
            return v;
        end
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic data_txn(input string tag, input logic we, input logic [1:0] sz,
                            input logic se, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int dly);
        logic ill;
        ill = m_illegal(sz, addr);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_size = sz; d_se = se; d_addr = addr; d_wdata = wd;
        @(negedge clk); #1;
        if (ill) begin
            vectors++;
            if (d_ack !== 1'b1 || d_err !== 1'b1 || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL %s fault: ack/err/req got %b%b%b expected 110", tag, d_ack, d_err, mem_req);
            end
            @(negedge clk);
            d_req = 1'b0; #1;
            vectors++;
            if (d_ack !== 1'b0 || d_err !== 1'b0 || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL %s fault_end: ack/err/req got %b%b%b expected 000", tag, d_ack, d_err, mem_req);
            end
        end else begin
            vectors++;
            if ({mem_req, mem_we, mem_be} !== {1'b1, we, m_be(sz, addr)}) begin
                miscompares++;
                $display("FAIL %s port: req/we/be got %b %b %b expected 1 %b %b",
                         tag, mem_req, mem_we, mem_be, we, m_be(sz, addr));
            end
            vectors++;
            if (mem_addr !== 30'(addr / 32'd4)) begin
                miscompares++;
                $display("FAIL %s addr: got %h expected %h", tag, mem_addr, 30'(addr / 32'd4));
            end
            if (we) begin
                vectors++;
                if (mem_wdata !== m_wdata(sz, wd)) begin
                    miscompares++;
                    $display("FAIL %s wdata: got %h expected %h", tag, mem_wdata, m_wdata(sz, wd));
                end
            end
            for (int k = 0; k < dly; k++) begin
                mem_rdata = $urandom; #1;
                vectors++;
                if (d_ack !== 1'b0 || mem_req !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s wait: ack/req got %b%b expected 01", tag, d_ack, mem_req);
                end
                @(negedge clk);
            end
            mem_ready = 1'b1; mem_rdata = rd; #1;
            vectors++;
            if (d_ack !== 1'b1 || d_err !== 1'b0 || i_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL %s ack: d_ack/d_err/i_ack got %b%b%b expected 100", tag, d_ack, d_err, i_ack);
            end
            if (!we) begin
                vectors++;
                if (d_rdata !== m_rdata(sz, se, addr, rd)) begin
                    miscompares++;
                    $display("FAIL %s rdata: got %h expected %h", tag, d_rdata, m_rdata(sz, se, addr, rd));
                end
            end
            @(negedge clk);
            mem_ready = 1'b0; d_req = 1'b0; #1;
            vectors++;
            if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL %s done: req/ack got %b%b expected 00", tag, mem_req, d_ack);
            end
        end
    endtask

    task automatic fetch_txn(input string tag, input logic [31:0] addr,
                             input logic [31:0] rd, input int dly);
        @(negedge clk);
        i_req = 1'b1; i_addr = addr;
        @(negedge clk); #1;
        vectors++;
        if ({mem_req, mem_we, mem_be} !== 6'b10_1111 || mem_addr !== 30'(addr / 32'd4)) begin
            miscompares++;
            $display("FAIL %s port: req/we/be/addr got %b %b %b %h expected 1 0 1111 %h",
                     tag, mem_req, mem_we, mem_be, mem_addr, 30'(addr / 32'd4));
        end
        for (int k = 0; k < dly; k++) begin
            mem_rdata = $urandom; #1;
            vectors++;
            if (i_ack !== 1'b0 || i_rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL %s wait: i_ack got %b i_rdata %h expected 0 0", tag, i_ack, i_rdata);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1; mem_rdata = rd; #1;
        vectors++;
        if (i_ack !== 1'b1 || i_rdata !== rd || d_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ack: i_ack %b d_ack %b rdata %h expected 1 0 %h", tag, i_ack, d_ack, i_rdata, rd);
        end
        @(negedge clk);
        mem_ready = 1'b0; i_req = 1'b0; #1;
        vectors++;
        if (mem_req !== 1'b0 || i_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done: req/ack got %b%b expected 00", tag, mem_req, i_ack);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_b = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
        vectors++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, i_ack, i_rdata, d_ack, d_rdata, d_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req %b we %b be %b addr %h wd %h i_ack %b d_ack %b d_err %b expected all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, i_ack, d_ack, d_err);
        end
        repeat (2) @(negedge clk);
        mem_ready = 1'b0; rst_b = 1'b1; #1;
        vectors++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: req/ack got %b%b expected 00", mem_req, d_ack);
        end
    endtask

    task automatic test_directed();
        fetch_txn("fetch_0x100", 32'h0000_0100, 32'hDEAD_BEEF, 1);
        data_txn("ldb_se1", 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'h0000_00F0, 0);
        data_txn("ldb_se0", 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 32'h0000_00F0, 1);
        data_txn("sth_0x12", 1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 0);
        data_txn("ldh_se", 1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, 32'h8001_7FFF, 2);
        data_txn("fault_w6", 1'b0, 2'b11, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0);
        data_txn("fault_sz10", 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h5555_5555, 32'h0, 0);
        data_txn("fault_h1", 1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0);
    endtask

    task automatic test_stray_ready();
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678; #1;
        vectors++;
        if (i_ack !== 1'b0 || d_ack !== 1'b0 || d_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL stray_ready: i_ack/d_ack got %b%b d_rdata %h expected 00 0", i_ack, d_ack, d_rdata);
        end
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic test_priority();
        logic last_d;
        logic exp_d;
        logic rr;
`ifdef JPU_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        apply_reset();
        last_d = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_se = 1'b0; d_addr = 32'h0000_2000;
        for (int n = 0; n < 4; n++) begin
            exp_d = rr ? !last_d : 1'b1;
            last_d = exp_d;
            @(negedge clk);
            mem_ready = 1'b1; mem_rdata = $urandom; #1;
            vectors++;
            if (mem_addr !== (exp_d ? 30'h800 : 30'h400) || d_ack !== exp_d || i_ack !== !exp_d) begin
                miscompares++;
                $display("FAIL prio_%0d: addr %h d_ack %b i_ack %b expected data=%b", n, mem_addr, d_ack, i_ack, exp_d);
            end
            @(negedge clk);
            mem_ready = 1'b0; #1;
            vectors++;
            if (mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL prio_gap_%0d: mem_req got %b expected 0", n, mem_req);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_addr = 32'h0000_0040;
        @(negedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL inflight_busy: mem_req got %b expected 1", mem_req);
        end
        rst_b = 1'b0; mem_ready = 1'b1; #1;
        vectors++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0 || d_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL inflight_reset: req/ack got %b%b rdata %h expected 00 0", mem_req, d_ack, d_rdata);
        end
        d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL inflight_idle: req/ack got %b%b expected 00", mem_req, d_ack);
        end
        fetch_txn("post_reset_fetch", 32'h0000_0ABC, 32'hCAFE_F00D, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                fetch_txn("rnd_fetch", a, $urandom, $urandom_range(0, 3));
            end else begin
                data_txn("rnd_data", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        rst_b = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_size = 2'b00; d_se = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0;
        test_reset();
        test_directed();
        test_stray_ready();
        test_priority();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
